// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes and the AXI4-Lite master FSM state type.
package axi_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;

    // Read data reported when the watchdog abandons a transaction
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } axi_lite_mst_state_e;

endpackage

// File: rtl/axi_lite_mst_watchdog.sv
// axi_lite_mst_watchdog: counts cycles spent waiting on the slave and flags
// expiry in the cycle whose edge would bring the count to LIMIT, so the
// master reaches its response state exactly LIMIT cycles after it starts
// waiting.
module axi_lite_mst_watchdog #(
    parameter int  LIMIT = 256,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(LIMIT - 1));

    // Wait-cycle counter; restarts on every accepted command, saturates at expiry
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master. One command is taken
// on the cmd_* port, the AW/W/B or AR/R exchange is run, and the slave's
// response is held on rsp_* until consumed.
// Optional watchdog: define AXI_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master
    import axi_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    // command / response side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI4-Lite write channels
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI4-Lite read channels
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    axi_lite_mst_state_e   state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  timeout;
    logic                  aw_done;
    logic                  w_done;

    // Captured command drives the AXI payload, so it is stable while valid is high
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    // A channel is finished once its valid has dropped or it handshakes now
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = cmd_valid && cmd_ready;
    assign wd_enable = (state == WR_REQ) || (state == WR_RESP) ||
                       (state == RD_REQ) || (state == RD_DATA);

    axi_lite_mst_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (aclk),
        .reset   (areset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;

    // No watchdog in this build: the limit is referenced only here
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Transaction FSM with registered handshake and response outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (timeout) begin
            // Abandon the slave; anything it sends later is not looked at
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= RESP_DECERR;
            rsp_rdata <= DATA_WIDTH'(TIMEOUT_RDATA);
            state     <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= rresp;
                        rsp_rdata <= rdata;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed bench for axi4_lite_master with a
// programmable-latency slave stub, a reference register map and a
// per-cycle checker of protocol rules and responses.
// Build with AXI_LITE_MASTER_TIMEOUT_EN to also exercise the watchdog.
module tb_axi4_lite_master;

    localparam int TO = 32;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 aclk = ~aclk;

    axi4_lite_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // all driving happens just after the rising edge
    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    // slave address map: 4 words at 0x0..0xC (CTRL=0x0, SCRATCH=0x8),
    // 0x100.. SLVERR, 0x1000.. DECERR
    function automatic logic [1:0] map_resp(input logic [31:0] a);
        if (a >= 32'h1000) return 2'b11;
        if (a >= 32'h100)  return 2'b10;
        return 2'b00;
    endfunction

    // ---------------- slave stub ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          slv_clr = 1'b1;
    int          aw_hs_n = 0, w_hs_n = 0;
    logic [31:0] smem [4];

    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_have, w_have, ar_have;
        logic [31:0] wa, wd, ra;
        logic [3:0]  ws;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        wa = 0; wd = 0; ra = 0; ws = 0;
        forever begin
            step();
            if (slv_clr) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_have = 0; w_have = 0; ar_have = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                slv_clr = 0;
            end else begin
                // handshakes completed on the edge just passed
                if (aw_fire) begin aw_have = 1; aw_hs_n++; end
                if (w_fire)  begin w_have = 1;  w_hs_n++;  end
                if (b_fire)  begin bvalid = 0; aw_have = 0; w_have = 0; b_cnt = 0; end
                if (ar_fire) ar_have = 1;
                if (r_fire)  begin rvalid = 0; ar_have = 0; r_cnt = 0; end

                if (awvalid && !aw_have) begin aw_cnt++; awready = (aw_cnt > aw_dly); end
                else begin aw_cnt = 0; awready = 0; end
                if (wvalid && !w_have) begin w_cnt++; wready = (w_cnt > w_dly); end
                else begin w_cnt = 0; wready = 0; end
                if (arvalid && !ar_have) begin ar_cnt++; arready = (ar_cnt > ar_dly); end
                else begin ar_cnt = 0; arready = 0; end

                if (aw_have && w_have && !bvalid) begin
                    if (b_cnt == 0 && map_resp(wa) == 2'b00 && wa < 32'h10)
                        for (int b = 0; b < 4; b++)
                            if (ws[b]) smem[wa[3:2]][8*b +: 8] = wd[8*b +: 8];
                    b_cnt++;
                    if (b_dly >= 0 && b_cnt > b_dly) begin bvalid = 1; bresp = map_resp(wa); end
                end
                if (ar_have && !rvalid) begin
                    r_cnt++;
                    if (r_cnt > r_dly) begin
                        rvalid = 1;
                        rresp  = map_resp(ra);
                        rdata  = (rresp == 2'b00 && ra < 32'h10) ? smem[ra[3:2]] : 32'h0;
                    end
                end

                aw_fire = awvalid && awready; if (aw_fire) wa = awaddr;
                w_fire  = wvalid && wready;   if (w_fire) begin wd = wdata; ws = wstrb; end
                ar_fire = arvalid && arready; if (ar_fire) ra = araddr;
                b_fire  = bvalid && bready;
                r_fire  = rvalid && rready;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t        expq [$];
    logic [31:0] ref_mem [4] = '{default: 32'h0};
    logic [31:0] cur_addr = 0, cur_wdata = 0;
    logic [3:0]  cur_wstrb = 0;
    bit          to_mode = 1'b0;
    int          rsp_pulses = 0;

    // per-cycle checker
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rspv = 0;
    always @(negedge aclk) begin
        if (areset) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rspv = 0;
        end else begin
            if (awvalid) begin chk("awprot", awprot, 0); chk("awaddr", awaddr, cur_addr); end
            if (wvalid)  begin chk("wdata", wdata, cur_wdata); chk("wstrb", wstrb, cur_wstrb); end
            if (arvalid) begin chk("arprot", arprot, 0); chk("araddr", araddr, cur_addr); end
            if (p_awv && p_awr) chk("aw_drop", awvalid, 0);
            else if (p_awv && !to_mode) chk("aw_hold", awvalid, 1);
            if (p_wv && p_wr) chk("w_drop", wvalid, 0);
            else if (p_wv && !to_mode) chk("w_hold", wvalid, 1);
            if (p_arv && p_arr) chk("ar_drop", arvalid, 0);
            else if (p_arv && !to_mode) chk("ar_hold", arvalid, 1);
            if (awvalid && !p_awv) chk("w_with_aw", wvalid, 1);
            if (cmd_ready) chk("idle_quiet", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
            if (awvalid || wvalid || bready) chk("one_outstanding", {arvalid, rready}, 0);
            if (rsp_valid) begin
                if (expq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    chk("rsp_rdata", rsp_rdata, expq[0].rdata);
                    chk("rsp_resp", rsp_resp, expq[0].resp);
                    if (rsp_ready) void'(expq.pop_front());
                end
                if (!p_rspv) rsp_pulses++;
            end
            p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_arv = arvalid; p_arr = arready; p_rspv = rsp_valid;
        end
    end

    // issue one command, hold rsp_ready low for 'hold' cycles, return the response
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold,
                          output logic [31:0] rd, output logic [1:0] rs, output int lat);
        rsp_t e;
        int   n;
        e.resp = map_resp(addr);
        if (wr) begin
            e.rdata = '0;
            if (e.resp == 2'b00 && addr < 32'h10)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[addr[3:2]][8*b +: 8] = data[8*b +: 8];
        end else begin
            e.rdata = (e.resp == 2'b00 && addr < 32'h10) ? ref_mem[addr[3:2]] : 32'h0;
        end
        if (to_mode) begin e.rdata = 32'hDEADDEAD; e.resp = 2'b11; end
        expq.push_back(e);
        cur_addr = addr; cur_wdata = data; cur_wstrb = strb;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 100) begin step(); n++; end
        chk("cmd_accept", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("req_latency_aw", awvalid, wr);
        chk("req_latency_w", wvalid, wr);
        chk("req_latency_ar", arvalid, !wr);
        n = 0;
        while (!rsp_valid && n < 200) begin step(); n++; end
        chk("rsp_arrives", rsp_valid, 1);
        lat = n;
        rd = rsp_rdata; rs = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, e.rdata);
            chk("hold_resp", rsp_resp, e.resp);
        end
        chk("cmd_ready_before_ack", cmd_ready, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("cmd_ready_after_ack", cmd_ready, 1);
        chk("rsp_valid_after_ack", rsp_valid, 0);
    endtask

    initial begin : global_limit
        #500000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat, n, a0, w0, p0;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) step();
        areset = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        step();

        // write then read CTRL
        do_cmd(1, 32'h0, 32'hCAFEBABE, 4'hF, 0, rd, rs, lat);
        chk("ctrl_wr_resp", rs, 2'b00);
        chk("ctrl_wr_rdata", rd, 0);
        do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("ctrl_rd_data", rd, 32'hCAFEBABE);
        chk("ctrl_rd_resp", rs, 2'b00);

        // SLVERR region
        do_cmd(1, 32'h100, 32'h55AA55AA, 4'hF, 0, rd, rs, lat);
        chk("slverr_wr_resp", rs, 2'b10);
        do_cmd(0, 32'h100, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("slverr_rd_resp", rs, 2'b10);

        // AW late / W late orderings
        aw_dly = 3; w_dly = 0;
        a0 = aw_hs_n; w0 = w_hs_n; p0 = rsp_pulses;
        do_cmd(1, 32'h8, 32'h11112222, 4'hF, 0, rd, rs, lat);
        chk("awlate_aw_hs", aw_hs_n - a0, 1);
        chk("awlate_w_hs", w_hs_n - w0, 1);
        chk("awlate_pulses", rsp_pulses - p0, 1);
        aw_dly = 0; w_dly = 3;
        a0 = aw_hs_n; w0 = w_hs_n; p0 = rsp_pulses;
        do_cmd(1, 32'hC, 32'h33334444, 4'hF, 0, rd, rs, lat);
        chk("wlate_aw_hs", aw_hs_n - a0, 1);
        chk("wlate_w_hs", w_hs_n - w0, 1);
        chk("wlate_pulses", rsp_pulses - p0, 1);
        w_dly = 0;

        // response held off for 10 cycles
        do_cmd(1, 32'h4, 32'h12345678, 4'hF, 0, rd, rs, lat);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 10, rd, rs, lat);
        chk("hold_rd_data", rd, 32'h12345678);
        chk("hold_rd_resp", rs, 2'b00);

        // slow slave on all channels
        ar_dly = 2; r_dly = 3; b_dly = 2;
        do_cmd(0, 32'hC, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("slow_rd_data", rd, 32'h33334444);
        // write after a non-zero read returns zero data
        do_cmd(1, 32'h0, 32'h1234FFFF, 4'h3, 0, rd, rs, lat);
        chk("wr_after_rd_rdata", rd, 0);
        ar_dly = 0; r_dly = 0; b_dly = 0;
        do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("partial_ctrl", rd, 32'hCAFEFFFF);

        // DECERR passthrough
        do_cmd(0, 32'h2000, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("decerr_resp", rs, 2'b11);

        // reset while waiting for read data
        r_dly = 20;
        cur_addr = 32'hC;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hC;
        n = 0;
        while (!cmd_ready && n < 100) begin step(); n++; end
        step();
        cmd_valid = 0;
        n = 0;
        while (!rready && n < 50) begin step(); n++; end
        chk("reached_rd_data", rready, 1);
        areset = 1; slv_clr = 1;
        step();
        areset = 0;
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_rready", rready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        step();
        r_dly = 0;
        do_cmd(1, 32'h8, 32'h4, 4'hF, 0, rd, rs, lat);
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("scratch_after_rst", rd, 32'h4);

        // byte strobes
        do_cmd(1, 32'h8, 32'hAABBCCDD, 4'h5, 0, rd, rs, lat);
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("strobe_merge", rd, 32'h00BB00DD);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // slave never answers the write
        b_dly = -1; to_mode = 1;
        do_cmd(1, 32'h0, 32'h01020304, 4'hF, 0, rd, rs, lat);
        chk("to_latency", lat, TO);
        chk("to_rdata", rd, 32'hDEADDEAD);
        chk("to_resp", rs, 2'b11);
        to_mode = 0; slv_clr = 1;
        step();
        b_dly = 0;
        do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, lat);
        chk("after_to_rd", rd, 32'h01020304);
`endif

        chk("queue_drained", expq.size(), 0);
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, watchdog limit (REQ-016).

REQ-002 The block SHALL have these ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1; awready  in  1.
- wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1; wready  in  1.
- bresp  in  2; bvalid  in  1; bready  out  1.
- araddr/arprot/arvalid  out  ADDR_WIDTH/3/1; arready  in  1.
- rdata  in  DATA_WIDTH; rresp  in  2; rvalid  in  1; rready  out  1.

Function
REQ-003 The FSM SHALL have these states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted and registered on cmd_valid && cmd_ready.
REQ-005 On acceptance, IDLE SHALL move to WR_REQ if cmd_write=1, else to RD_REQ; AXI valids SHALL assert on the next cycle (1-cycle latency).
REQ-006 In WR_REQ, awvalid and wvalid SHALL assert together, and each SHALL drop independently in the cycle after its own handshake.
REQ-007 Once both AW and W handshakes complete, same cycle or any order, the FSM SHALL move to WR_RESP.
REQ-008 awaddr, awprot, wdata and wstrb SHALL stay stable while the matching valid is high; awprot and arprot SHALL be 3'b000.
REQ-009 In WR_RESP, bready SHALL be 1; on bvalid, bresp SHALL be captured, rsp_rdata set to 0, and the FSM SHALL move to RSP.
REQ-010 In RD_REQ, arvalid SHALL be 1 until arready, then the FSM SHALL move to RD_DATA; araddr SHALL be stable while arvalid is high.
REQ-011 In RD_DATA, rready SHALL be 1; on rvalid, rdata and rresp SHALL be captured and the FSM SHALL move to RSP.
REQ-012 In RSP, rsp_valid SHALL be 1 and rsp_rdata/rsp_resp SHALL be held until rsp_ready; on rsp_ready the FSM SHALL return to IDLE, so cmd_ready is 1 on the next cycle.
REQ-013 Only one transaction SHALL be outstanding; bready and rready SHALL be 0 outside WR_RESP and RD_DATA respectively.
REQ-014 The slave response code SHALL be passed through unmodified (OKAY 00, SLVERR 10, DECERR 11).

Reset
REQ-015 On areset=1 at a clock edge, the FSM SHALL go to IDLE on that edge, including mid-transaction. All valid/ready outputs SHALL be 0 except cmd_ready, which SHALL be 1 after reset release. rsp_rdata, rsp_resp, the captured command and the watchdog counter SHALL be 0.

Configuration
REQ-016 With AXI_LITE_MASTER_TIMEOUT_EN defined:
- A counter SHALL clear on command acceptance and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
- When the counter reaches TIMEOUT_CYCLES, all AXI valids and readies SHALL drop, rsp_resp SHALL be 2'b11, rsp_rdata SHALL be 32'hDEADDEAD, and the FSM SHALL move to RSP.
- Late bvalid or rvalid SHALL be ignored.
REQ-017 Without the macro, no counter SHALL exist and the FSM SHALL wait indefinitely; TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-018 axi_pkg SHALL hold RESP_OKAY, RESP_SLVERR and RESP_DECERR, plus a new axi_lite_mst_state_e enum for the FSM states.
REQ-019 The watchdog SHALL be one sub-module, axi_lite_mst_watchdog (inputs clear/enable, output expired), instantiated only under AXI_LITE_MASTER_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-020 Back-to-back master driving axi4_lite_slave: write REG_CTRL_OFFSET 0xCAFEBABE, strb 1111 -> rsp_resp 00; then read -> rsp_rdata 0xCAFEBABE, rsp_resp 00.
REQ-021 Write then read of address 0x100 -> rsp_resp 10 for both; read rsp_rdata is whatever the slave returns.
REQ-022 Responder stub: awready 3 cycles after awvalid and wready immediately, then the reverse order -> exactly one AW and one W handshake each, one rsp_valid pulse, awvalid/wvalid each drop the cycle after their handshake.
REQ-023 rsp_ready held low 10 cycles after a read of 0x12345678 -> rsp_valid, rsp_rdata and rsp_resp stable for all 10 cycles; cmd_ready 1 exactly one cycle after rsp_ready rises.
REQ-024 Macro defined, stub never asserts bvalid -> rsp_valid with resp 11 and data 0xDEADDEAD exactly TIMEOUT_CYCLES cycles after entering WR_REQ.
REQ-025 areset pulsed while in RD_DATA -> next cycle arvalid=rready=rsp_valid=0 and cmd_ready=1; a subsequent write of 0x4 to SCRATCH reads back 0x4.
